// File: rtl/node_router_if.sv
// Node-side router port adapter: 32-bit core packets <-> 4-byte router bursts, FIFO-buffered both ways.
// TX byte0 two cycles after accept, pkt_in_ready low while TX FIFO full; RX packet two cycles after last byte, free_outbound low while busy or full.

module nr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so push-at-full is accepted then
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

module node_router_if #(
  parameter int NODEID   = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int MAX_DEST = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pkt_in,
  input  logic        pkt_in_valid,
  output logic        pkt_in_ready,
  input  logic        free_inbound,
  output logic        put_inbound,
  output logic [7:0]  payload_inbound,
  input  logic        put_outbound,
  input  logic [7:0]  payload_outbound,
  output logic        free_outbound,
  output logic [31:0] pkt_out,
  output logic        pkt_out_valid,
  input  logic        pkt_out_ready,
  output logic        tx_drop,
  output logic        rx_err
);
  localparam logic [31:0] SRC_FIELD  = {4'(NODEID), 28'h0};
  localparam logic [31:0] SRC_MASK   = 32'h0FFF_FFFF;
  localparam logic [3:0]  MAX_DEST_C = 4'(MAX_DEST);

  typedef enum logic [2:0] {T_IDLE, T_B0, T_B1, T_B2, T_B3, T_GAP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_B1, R_B2, R_B3, R_WR} rx_state_t;

  tx_state_t   tx_state;
  rx_state_t   rx_state;

  logic        tx_accept;
  logic        tx_legal;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic [31:0] tx_wdat;
  logic [31:0] tx_head;
  logic [31:0] tx_shift;

  logic        rx_push;
  logic        rx_pop;
  logic        rx_full;
  logic        rx_empty;
  logic [31:0] rx_shift;

  // src is always overwritten with our own node number
  assign tx_wdat      = (pkt_in & SRC_MASK) | SRC_FIELD;
  assign pkt_in_ready = !tx_full;
  assign tx_accept    = pkt_in_valid && pkt_in_ready;
  assign tx_legal     = (pkt_in[27:24] <= MAX_DEST_C);
  assign tx_push      = tx_accept && tx_legal;
  assign tx_pop       = (tx_state == T_IDLE) && !tx_empty && free_inbound;

  nr_fifo #(.WIDTH(32), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (tx_push),
    .din     (tx_wdat),
    .pop     (tx_pop),
    .dout    (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  // outputs lag the state by one edge: state T_Bk drives byte k on the following cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tx_state        <= T_IDLE;
      tx_shift        <= '0;
      put_inbound     <= 1'b0;
      payload_inbound <= '0;
      tx_drop         <= 1'b0;
    end else begin
      tx_drop <= tx_accept && !tx_legal;
      case (tx_state)
        T_IDLE: begin
          put_inbound     <= 1'b0;
          payload_inbound <= '0;
          if (tx_pop) begin
            tx_shift <= tx_head;
            tx_state <= T_B0;
          end
        end
        T_B0: begin
          put_inbound     <= 1'b1;
          payload_inbound <= tx_shift[31:24];
          tx_state        <= T_B1;
        end
        T_B1: begin
          put_inbound     <= 1'b1;
          payload_inbound <= tx_shift[23:16];
          tx_state        <= T_B2;
        end
        T_B2: begin
          put_inbound     <= 1'b1;
          payload_inbound <= tx_shift[15:8];
          tx_state        <= T_B3;
        end
        T_B3: begin
          put_inbound     <= 1'b1;
          payload_inbound <= tx_shift[7:0];
          tx_state        <= T_GAP;
        end
        T_GAP: begin
          put_inbound     <= 1'b0;
          payload_inbound <= '0;
          tx_state        <= T_IDLE;
        end
        default: begin
          put_inbound     <= 1'b0;
          payload_inbound <= '0;
          tx_state        <= T_IDLE;
        end
      endcase
    end
  end

  assign free_outbound = (rx_state == R_IDLE) && !rx_full;
  assign rx_push       = (rx_state == R_WR);
  assign pkt_out_valid = !rx_empty;
  assign rx_pop        = pkt_out_ready && pkt_out_valid;

  nr_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (rx_push),
    .din     (rx_shift),
    .pop     (rx_pop),
    .dout    (pkt_out),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_state <= R_IDLE;
      rx_shift <= '0;
      rx_err   <= 1'b0;
    end else begin
      rx_err <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (put_outbound && free_outbound) begin
            rx_shift <= {rx_shift[23:0], payload_outbound};
            rx_state <= R_B1;
          end
        end
        R_B1, R_B2, R_B3: begin
          if (put_outbound) begin
            rx_shift <= {rx_shift[23:0], payload_outbound};
            case (rx_state)
              R_B1:    rx_state <= R_B2;
              R_B2:    rx_state <= R_B3;
              default: rx_state <= R_WR;
            endcase
          end else begin
            // a hole inside a burst means the router truncated it
            rx_err   <= 1'b1;
            rx_state <= R_IDLE;
          end
        end
        R_WR: begin
          rx_state <= R_IDLE;
        end
        default: begin
          rx_state <= R_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_node_router_if.sv
// Randomized + directed bench for node_router_if with queue scoreboards for both directions.
module tb_node_router_if;
  localparam int NODEID   = 2;
  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;
  localparam int MAX_DEST = 5;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pkt_in = '0;
  logic        pkt_in_valid = 1'b0;
  logic        pkt_in_ready;
  logic        free_inbound = 1'b0;
  logic        put_inbound;
  logic [7:0]  payload_inbound;
  logic        put_outbound = 1'b0;
  logic [7:0]  payload_outbound = '0;
  logic        free_outbound;
  logic [31:0] pkt_out;
  logic        pkt_out_valid;
  logic        pkt_out_ready = 1'b0;
  logic        tx_drop;
  logic        rx_err;

  always #5 clock = ~clock;

  node_router_if #(.NODEID(NODEID), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .MAX_DEST(MAX_DEST)) dut (
    .clock(clock), .reset_n(reset_n),
    .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
    .free_inbound(free_inbound), .put_inbound(put_inbound), .payload_inbound(payload_inbound),
    .put_outbound(put_outbound), .payload_outbound(payload_outbound), .free_outbound(free_outbound),
    .pkt_out(pkt_out), .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready),
    .tx_drop(tx_drop), .rx_err(rx_err)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] tx_exp[$];
  logic [31:0] rx_exp[$];
  int          drop_exp = 0, drop_seen = 0;
  int          err_exp = 0, err_seen = 0;
  bit          mon_hold = 1'b0;
  bit          rnd_done = 1'b0;
  bit          seen_put;
  int          tx_run = 0;
  logic [31:0] tx_acc = '0;
  int          rx_len;
  int          waited;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    checks++;
    failures++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  // Reference model: what the router must see for a core packet
  function automatic logic [31:0] tx_model(input logic [31:0] p);
    logic [3:0] src;
    src = 4'(NODEID);
    return {src, p[27:0]};
  endfunction

  // Caller is just after a posedge; returns just after the accepting posedge.
  task automatic send_tx(input logic [31:0] p);
    int w;
    w = 0;
    pkt_in = p;
    pkt_in_valid = 1'b1;
    @(negedge clock);
    while (!pkt_in_ready && w < 300) begin
      @(negedge clock);
      w++;
    end
    if (!pkt_in_ready) fail_now("tx_ready_timeout", "pkt_in_ready never rose");
    else if (int'(p[27:24]) <= MAX_DEST) tx_exp.push_back(tx_model(p));
    else drop_exp++;
    @(posedge clock);
    #1;
    pkt_in_valid = 1'b0;
  endtask

  // Router-side burst of len bytes (len<4 is a truncated burst)
  task automatic send_rx(input logic [31:0] w, input int len);
    int t;
    t = 0;
    @(negedge clock);
    while (!free_outbound && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!free_outbound) begin
      fail_now("rx_free_timeout", "free_outbound never rose");
      return;
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clock);
      #1;
      put_outbound = 1'b1;
      payload_outbound = w[31-8*i -: 8];
    end
    @(posedge clock);
    #1;
    put_outbound = 1'b0;
    payload_outbound = '0;
    if (len == 4) rx_exp.push_back(w);
    else err_exp++;
  endtask

  // TX monitor: reassembles bursts and checks framing and gap
  initial begin
    forever begin
      @(negedge clock);
      if (mon_hold || !reset_n) begin
        tx_run = 0;
      end else if (put_inbound) begin
        tx_run++;
        tx_acc = {tx_acc[23:0], payload_inbound};
        if (tx_run == 4) begin
          if (tx_exp.size() == 0) fail_now("tx_unexpected_burst", $sformatf("got %h, none expected", tx_acc));
          else chk("tx_burst", tx_acc, tx_exp.pop_front());
        end else if (tx_run == 5) begin
          fail_now("tx_gap", "put_inbound high 5 cycles, required 4 then low");
        end
      end else begin
        if (tx_run >= 1 && tx_run <= 3) fail_now("tx_short_burst", $sformatf("put_inbound high %0d cycles, required 4", tx_run));
        if (tx_run >= 4) chk("tx_gap_payload", payload_inbound, 0);
        tx_run = 0;
      end
    end
  end

  // RX monitor: compares each popped packet, counts pulses
  initial begin
    forever begin
      @(negedge clock);
      if (!mon_hold && reset_n) begin
        if (tx_drop) drop_seen++;
        if (rx_err) err_seen++;
        if (pkt_out_valid && pkt_out_ready) begin
          if (rx_exp.size() == 0) fail_now("rx_unexpected_pkt", $sformatf("got %h, none expected", pkt_out));
          else chk("rx_pkt", pkt_out, rx_exp.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    fail_now("watchdog", "simulation time limit exceeded");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_put", put_inbound, 0);
    chk("rst_payload", payload_inbound, 0);
    chk("rst_pkt_out_valid", pkt_out_valid, 0);
    chk("rst_tx_drop", tx_drop, 0);
    chk("rst_rx_err", rx_err, 0);
    chk("rst_pkt_in_ready", pkt_in_ready, 1);
    chk("rst_free_outbound", free_outbound, 1);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // single TX packet, latency and byte order
    @(posedge clock); #1;
    free_inbound = 1'b1;
    send_tx(32'hF3AB_CDEF);
    @(negedge clock); chk("tx_lat_edge0", put_inbound, 0);
    @(negedge clock); chk("tx_lat_edge1", put_inbound, 0);
    @(negedge clock); chk("tx_lat_edge2_put", put_inbound, 1);
    chk("tx_lat_edge2_byte0", payload_inbound, 8'h23);
    repeat (8) @(negedge clock);
    chk("tx_no_drop", drop_seen, 0);

    // illegal dest dropped, then the largest legal dest
    @(posedge clock); #1;
    send_tx(32'h0912_3456);
    @(negedge clock);
    chk("tx_drop_pulse", tx_drop, 1);
    chk("tx_drop_ready", pkt_in_ready, 1);
    @(negedge clock);
    chk("tx_drop_one_cycle", tx_drop, 0);
    repeat (8) @(negedge clock);
    chk("tx_drop_count", drop_seen, drop_exp);
    @(posedge clock); #1;
    send_tx(32'h0501_0203);
    repeat (10) @(negedge clock);
    chk("tx_dest_max_sent", tx_exp.size(), 0);

    // fill TX FIFO with router busy
    @(posedge clock); #1;
    free_inbound = 1'b0;
    for (int k = 0; k < TX_DEPTH; k++) begin
      @(posedge clock); #1;
      send_tx({4'h0, 4'(k), 24'(32'h00A000 + k)});
    end
    @(negedge clock);
    chk("tx_full_ready", pkt_in_ready, 0);
    @(posedge clock); #1;
    pkt_in = 32'h0100_0001;
    pkt_in_valid = 1'b1;
    seen_put = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (put_inbound) seen_put = 1'b1;
    end
    @(posedge clock); #1;
    pkt_in_valid = 1'b0;
    chk("tx_hold_while_busy", seen_put, 0);
    free_inbound = 1'b1;
    waited = 0;
    while (tx_exp.size() != 0 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    repeat (4) @(negedge clock);
    chk("tx_fill_drained", tx_exp.size(), 0);

    // single RX burst
    pkt_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      put_outbound = 1'b1;
      payload_outbound = (i == 0) ? 8'h50 : (i == 1) ? 8'h11 : (i == 2) ? 8'h22 : 8'h33;
      @(negedge clock);
      chk($sformatf("rx_free_byte%0d", i), free_outbound, (i == 0) ? 1 : 0);
    end
    @(posedge clock); #1;
    put_outbound = 1'b0;
    payload_outbound = '0;
    rx_exp.push_back(32'h5011_2233);
    @(negedge clock);
    chk("rx_lat1_valid", pkt_out_valid, 0);
    chk("rx_lat1_free", free_outbound, 0);
    @(negedge clock);
    chk("rx_lat2_valid", pkt_out_valid, 1);
    chk("rx_lat2_data", pkt_out, 32'h5011_2233);
    @(negedge clock);
    chk("rx_stable_data", pkt_out, 32'h5011_2233);
    @(posedge clock); #1; pkt_out_ready = 1'b1;
    @(posedge clock); #1; pkt_out_ready = 1'b0;
    @(negedge clock);
    chk("rx_popped_empty", pkt_out_valid, 0);

    // fill RX FIFO, stray burst while full, pop, truncated burst
    for (int k = 0; k < RX_DEPTH; k++) send_rx($urandom, 4);
    @(negedge clock);
    @(negedge clock);
    chk("rx_full_free", free_outbound, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      put_outbound = 1'b1;
      payload_outbound = 8'hEE;
    end
    @(posedge clock); #1;
    put_outbound = 1'b0;
    payload_outbound = '0;
    repeat (3) @(negedge clock);
    chk("rx_stray_free", free_outbound, 0);
    chk("rx_stray_no_err", err_seen, err_exp);
    @(posedge clock); #1; pkt_out_ready = 1'b1;
    @(posedge clock); #1; pkt_out_ready = 1'b0;
    @(negedge clock);
    chk("rx_free_after_pop", free_outbound, 1);
    send_rx(32'h7788_0000, 2);
    @(negedge clock); chk("rx_err_before", rx_err, 0);
    @(negedge clock); chk("rx_err_pulse", rx_err, 1);
    @(negedge clock); chk("rx_err_one_cycle", rx_err, 0);
    @(posedge clock); #1; pkt_out_ready = 1'b1;
    repeat (6) @(negedge clock);
    @(posedge clock); #1; pkt_out_ready = 1'b0;
    chk("rx_fill_drained", rx_exp.size(), 0);
    chk("rx_fill_empty", pkt_out_valid, 0);

    // randomized traffic in both directions
    rnd_done = 1'b0;
    fork
      begin
        fork
          begin
            for (int k = 0; k < 40; k++) begin
              repeat ($urandom_range(0, 3)) @(posedge clock);
              @(posedge clock); #1;
              send_tx($urandom);
            end
          end
          begin
            for (int k = 0; k < 30; k++) begin
              repeat ($urandom_range(0, 4)) @(posedge clock);
              rx_len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 4;
              send_rx($urandom, rx_len);
            end
          end
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #1;
          free_inbound = 1'($urandom_range(0, 1));
          pkt_out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    @(posedge clock); #1;
    free_inbound = 1'b1;
    pkt_out_ready = 1'b1;
    waited = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0) && waited < 1000) begin
      @(negedge clock);
      waited++;
    end
    repeat (8) @(negedge clock);
    chk("rnd_tx_drained", tx_exp.size(), 0);
    chk("rnd_rx_drained", rx_exp.size(), 0);
    chk("rnd_drop_count", drop_seen, drop_exp);
    chk("rnd_err_count", err_seen, err_exp);
    @(posedge clock); #1;
    pkt_out_ready = 1'b0;

    // reset in the middle of a TX burst with both FIFOs occupied
    mon_hold = 1'b1;
    send_rx(32'hA1B2_C3D4, 4);
    repeat (2) @(negedge clock);
    chk("rst_pre_rx_valid", pkt_out_valid, 1);
    @(posedge clock); #1;
    send_tx(32'h0412_3456);
    send_tx(32'h0300_0001);
    waited = 0;
    @(negedge clock);
    while (!put_inbound && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk("rst_pre_byte0", payload_inbound, 8'h24);
    @(negedge clock);
    @(negedge clock);
    chk("rst_pre_byte2", payload_inbound, 8'h34);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst_mid_put", put_inbound, 0);
    chk("rst_mid_payload", payload_inbound, 0);
    chk("rst_mid_pkt_in_ready", pkt_in_ready, 1);
    chk("rst_mid_free_outbound", free_outbound, 1);
    chk("rst_mid_pkt_out_valid", pkt_out_valid, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    seen_put = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (put_inbound) seen_put = 1'b1;
    end
    chk("rst_tx_fifo_cleared", seen_put, 0);
    chk("rst_rx_fifo_cleared", pkt_out_valid, 0);
    tx_exp.delete();
    rx_exp.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
